// File: rtl/mult_share_arbiter.sv
// Time-shares one grouped partial-product multiplier between NUM_REQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ          = 2,
  parameter int unsigned GROUPS           = 3,
  parameter int unsigned MULTIPLY_LATENCY = 2,
  localparam int unsigned ID_W   = $clog2(NUM_REQ),
  localparam int unsigned GSEL_W = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic              abort,
  output logic [NUM_REQ-1:0] ack,
  output logic [GSEL_W-1:0] mux_sel,
  output logic              pp_valid,
  output logic              final_en,
  output logic [ID_W-1:0]   owner_id,
  output logic              busy
);

  localparam int unsigned WAIT_W = (MULTIPLY_LATENCY > 1) ? $clog2(MULTIPLY_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MULTIPLY_LATENCY - 1);
  localparam logic [GSEL_W-1:0] GRP_LAST  = GSEL_W'(GROUPS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [GSEL_W-1:0] grp_q, grp_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win, idx;
  logic              found, grant, req_ok;
  int unsigned       sum;

  // Arbitration: first requester found scanning upward from the priority pointer.
  always_comb begin
    win   = '0;
    idx   = '0;
    sum   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      sum = k;
`else
      sum = 32'(ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
`endif
      idx = ID_W'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and strobe logic; a new grant is only possible in IDLE or on the terminal group.
  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    wait_d   = wait_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    ack      = '0;
    pp_valid = 1'b0;
    final_en = 1'b0;
    grant    = 1'b0;
    req_ok   = found && !abort && reset;

    case (state_q)
      S_IDLE: begin
        if (req_ok) grant = 1'b1;
      end
      S_BUSY: begin
        if (abort) begin
          state_d = S_IDLE;
          grp_d   = '0;
          wait_d  = WAIT_INIT;
        end else if (wait_q == '0) begin
          pp_valid = 1'b1;
          wait_d   = WAIT_INIT;
          if (grp_q == GRP_LAST) begin
            final_en = 1'b1;
            grp_d    = '0;
            if (req_ok) grant = 1'b1;
            else        state_d = S_IDLE;
          end else begin
            grp_d = grp_q + GSEL_W'(1);
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      ack     = NUM_REQ'(1) << win;
      owner_d = win;
      state_d = S_BUSY;
      grp_d   = '0;
      wait_d  = WAIT_INIT;
      ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      wait_q  <= WAIT_INIT;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
    end
  end

`ifdef MULT_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign busy     = (state_q == S_BUSY);
  assign mux_sel  = grp_q;
  assign owner_id = owner_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: default-parameter instance plus a GROUPS=1/LAT=1 instance.
module tb_mult_share_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req, req1;
  logic       abort;
  logic [1:0] ack, ack1;
  logic [1:0] mux_sel;
  logic [0:0] mux_sel1;
  logic       pp_valid, pp_valid1, final_en, final_en1, busy, busy1;
  logic [0:0] owner_id, owner_id1;

  int n_tests;
  int n_fail;

  mult_share_arbiter #(.NUM_REQ(2), .GROUPS(3), .MULTIPLY_LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .abort(abort), .ack(ack), .mux_sel(mux_sel),
    .pp_valid(pp_valid), .final_en(final_en), .owner_id(owner_id), .busy(busy)
  );

  mult_share_arbiter #(.NUM_REQ(2), .GROUPS(1), .MULTIPLY_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .abort(1'b0), .ack(ack1), .mux_sel(mux_sel1),
    .pp_valid(pp_valid1), .final_en(final_en1), .owner_id(owner_id1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int drain;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    req     = 2'b00;
    req1    = 2'b00;
    abort   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy",  32'(busy), 0);
    check("rst_ack",   32'(ack), 0);
    check("rst_mux",   32'(mux_sel), 0);
    check("rst_owner", 32'(owner_id), 0);
    check("rst_pp",    32'(pp_valid), 0);
    check("rst_final", 32'(final_en), 0);
    next_cyc();
    reset = 1'b1;

    // Reset mid-operation during group 1
    req = 2'b01;
    @(negedge clk);
    check("t1_ack", 32'(ack), 1);
    next_cyc();
    req = 2'b00;
    next_cyc();
    next_cyc();
    @(negedge clk);
    check("t1_grp1", 32'(mux_sel), 1);
    check("t1_busy", 32'(busy), 1);
    #1 reset = 1'b0;
    #1;
    check("t1_rst_busy",  32'(busy), 0);
    check("t1_rst_mux",   32'(mux_sel), 0);
    check("t1_rst_pp",    32'(pp_valid), 0);
    check("t1_rst_final", 32'(final_en), 0);
    check("t1_rst_ack",   32'(ack), 0);
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      @(negedge clk);
      check("t1_no_final", 32'(final_en), 0);
    end
    next_cyc();
    reset = 1'b1;

    // Back-to-back operations with both requesters held
    req = 2'b11;
    for (int c = 0; c <= 12; c++) begin
      logic [1:0] exp_ack;
      logic       exp_owner;
      @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_ack   = (c % 6 == 0) ? 2'b01 : 2'b00;
      exp_owner = 1'b0;
`else
      exp_ack   = (c % 6 != 0) ? 2'b00 : (c == 6) ? 2'b10 : 2'b01;
      exp_owner = (c >= 7) ? 1'b1 : 1'b0;
`endif
      check($sformatf("t3_ack_c%0d", c), 32'(ack), 32'(exp_ack));
      check($sformatf("t3_final_c%0d", c), 32'(final_en), 32'((c == 6 || c == 12) ? 1 : 0));
      if (c >= 1) begin
        check($sformatf("t3_busy_c%0d", c), 32'(busy), 1);
        check($sformatf("t3_owner_c%0d", c), 32'(owner_id), 32'(exp_owner));
      end
      next_cyc();
    end
    req = 2'b00;
    drain = 0;
    while (busy && drain < 12) begin
      next_cyc();
      drain++;
    end
    check("t3_drain", 32'(busy), 0);

    // Single operation timing
    next_cyc();
    req = 2'b01;
    for (int c = 0; c <= 7; c++) begin
      int exp_mux;
      if (c == 1) req = 2'b00;
      @(negedge clk);
      exp_mux = (c >= 1 && c <= 6) ? (c - 1) / 2 : 0;
      check($sformatf("t2_ack_c%0d", c), 32'(ack), 32'((c == 0) ? 1 : 0));
      check($sformatf("t2_mux_c%0d", c), 32'(mux_sel), 32'(exp_mux));
      check($sformatf("t2_pp_c%0d", c), 32'(pp_valid), 32'((c == 2 || c == 4 || c == 6) ? 1 : 0));
      check($sformatf("t2_final_c%0d", c), 32'(final_en), 32'((c == 6) ? 1 : 0));
      check($sformatf("t2_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 6) ? 1 : 0));
      if (c == 6) check("t2_owner", 32'(owner_id), 0);
      next_cyc();
    end

    // Abort mid-op, then grant next cycle
    req = 2'b01;
    @(negedge clk);
    check("t5_ack", 32'(ack), 1);
    next_cyc();
    req = 2'b00;
    next_cyc();
    next_cyc();
    abort = 1'b1;
    @(negedge clk);
    check("t5_abort_pp",    32'(pp_valid), 0);
    check("t5_abort_final", 32'(final_en), 0);
    check("t5_abort_busy",  32'(busy), 1);
    next_cyc();
    abort = 1'b0;
    req   = 2'b10;
    @(negedge clk);
    check("t5_idle",    32'(busy), 0);
    check("t5_regrant", 32'(ack), 2);
    check("t5_mux",     32'(mux_sel), 0);
    next_cyc();
    req = 2'b00;
    @(negedge clk);
    check("t5_owner", 32'(owner_id), 1);
    for (int c = 2; c <= 6; c++) next_cyc();
    abort = 1'b1;
    req   = 2'b01;
    @(negedge clk);
    check("t5_term_final", 32'(final_en), 0);
    check("t5_term_pp",    32'(pp_valid), 0);
    check("t5_term_ack",   32'(ack), 0);
    next_cyc();
    @(negedge clk);
    check("t5_term_idle", 32'(busy), 0);
    check("t5_idle_abort_ack", 32'(ack), 0);
    next_cyc();
    abort = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    check("t5_idle_abort_busy", 32'(busy), 0);

    // Single group, single-cycle latency: one op per cycle
    next_cyc();
    req1 = 2'b01;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t6_ack_c%0d", c), 32'(ack1), 1);
      check($sformatf("t6_pp_c%0d", c), 32'(pp_valid1), 32'((c > 0) ? 1 : 0));
      check($sformatf("t6_final_c%0d", c), 32'(final_en1), 32'((c > 0) ? 1 : 0));
      check($sformatf("t6_mux_c%0d", c), 32'(mux_sel1), 0);
      check($sformatf("t6_busy_c%0d", c), 32'(busy1), 32'((c > 0) ? 1 : 0));
      next_cyc();
    end
    req1 = 2'b00;
    @(negedge clk);
    check("t6_last_final", 32'(final_en1), 1);
    check("t6_last_ack",   32'(ack1), 0);
    next_cyc();
    @(negedge clk);
    check("t6_idle", 32'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
